// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared types and defaults for the RGB LED PWM stage
package rgb_led_pkg;

   // Colour channel selector carried on cfg_chan
   typedef enum logic [1:0] {
      CH_R    = 2'd0,
      CH_G    = 2'd1,
      CH_B    = 2'd2,
      CH_RSVD = 2'd3
   } chan_e;

   localparam int CFG_LED_W      = 4;
   localparam int DEF_PWM_BITS   = 8;
   localparam int DEF_PRESCALE   = 256;
   localparam int DEF_DUTY_RESET = 128;

   // A write is legal only if it names an existing LED and a real colour channel
   function automatic logic cfg_legal(input logic [CFG_LED_W-1:0] led,
                                      input logic [1:0]           chan,
                                      input int                   led_num);
      return ({1'b0, led} < (CFG_LED_W+1)'(led_num)) && (chan != CH_RSVD);
   endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one colour channel: shadow/active duty pair, compare and pad flop
module rgb_pwm_chan
   import rgb_led_pkg::*;
#(
   parameter int PWM_BITS       = DEF_PWM_BITS,
   parameter int DUTY_RESET     = DEF_DUTY_RESET,
   parameter int LED_ACTIVE_LOW = 1
) (
   input  logic                extra_clk,
   input  logic                extra_rst,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                wrap,
   input  logic                wr_en,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                en,
   output logic                pwm_out
);

   // Pad level that leaves the LED dark
   localparam logic DARK = (LED_ACTIVE_LOW != 0);

   logic [PWM_BITS-1:0] shadow;
   logic [PWM_BITS-1:0] active;
   logic                lit;

   // Writes land in the shadow; the active copy only follows at a period boundary,
   // so a write on the wrap cycle is seen one period later (active takes the old shadow)
   always_ff @(posedge extra_clk) begin
      if (extra_rst) begin
         shadow <= PWM_BITS'(DUTY_RESET);
         active <= PWM_BITS'(DUTY_RESET);
      end else begin
         if (wrap)
            active <= shadow;
         if (wr_en)
            shadow <= wr_duty;
      end
   end

   // Strict less-than: duty 0 is always off and full-on is unreachable by design
   assign lit = en && (pwm_cnt < active);

   // Registered pad drive, polarity folded in
   always_ff @(posedge extra_clk) begin
      if (extra_rst)
         pwm_out <= DARK;
      else
         pwm_out <= lit ^ DARK;
   end

endmodule

// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - per-LED RGB PWM dimmer gated by blink enables
module rgb_led_pwm
   import rgb_led_pkg::*;
#(
   parameter int LED_NUM        = 1,
   parameter int PWM_BITS       = DEF_PWM_BITS,
   parameter int PRESCALE       = DEF_PRESCALE,
   parameter int DUTY_RESET     = DEF_DUTY_RESET,
   parameter int LED_ACTIVE_LOW = 1
) (
   input  logic                 extra_clk,
   input  logic                 extra_rst,
   input  logic [LED_NUM-1:0]   en_r,
   input  logic [LED_NUM-1:0]   en_g,
   input  logic [LED_NUM-1:0]   en_b,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CFG_LED_W-1:0] cfg_led,
   input  logic [1:0]           cfg_chan,
   input  logic [PWM_BITS-1:0]  cfg_duty,
   output logic                 cfg_err,
   output logic [LED_NUM-1:0]   pwm_r,
   output logic [LED_NUM-1:0]   pwm_g,
   output logic [LED_NUM-1:0]   pwm_b,
   output logic                 period_start
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic                wrap;
   logic                cfg_accept;
   logic                cfg_ok;

   // With PRESCALE=1 the prescaler is pinned at 0 and tick stays high
   assign tick       = (pre_cnt == PRE_W'(PRESCALE - 1));
   assign wrap       = tick && (pwm_cnt == '1);
   assign cfg_accept = cfg_valid && cfg_ready;
   assign cfg_ok     = cfg_legal(cfg_led, cfg_chan, LED_NUM);

   // Prescaler and free-running PWM period counter
   always_ff @(posedge extra_clk) begin
      if (extra_rst) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Registered status: period marker, illegal-write pulse, config ready
   always_ff @(posedge extra_clk) begin
      if (extra_rst) begin
         period_start <= 1'b0;
         cfg_err      <= 1'b0;
         cfg_ready    <= 1'b0;
      end else begin
         period_start <= wrap;
         cfg_err      <= cfg_accept && !cfg_ok;
         cfg_ready    <= 1'b1;
      end
   end

   for (genvar i = 0; i < LED_NUM; i++) begin : g_led
      logic led_hit;
      logic wr_r;
      logic wr_g;
      logic wr_b;

      assign led_hit = cfg_accept && cfg_ok && (cfg_led == CFG_LED_W'(i));
      assign wr_r    = led_hit && (cfg_chan == CH_R);
      assign wr_g    = led_hit && (cfg_chan == CH_G);
      assign wr_b    = led_hit && (cfg_chan == CH_B);

      rgb_pwm_chan #(
         .PWM_BITS       (PWM_BITS),
         .DUTY_RESET     (DUTY_RESET),
         .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
      ) u_r (
         .extra_clk (extra_clk),
         .extra_rst (extra_rst),
         .pwm_cnt   (pwm_cnt),
         .wrap      (wrap),
         .wr_en     (wr_r),
         .wr_duty   (cfg_duty),
         .en        (en_r[i]),
         .pwm_out   (pwm_r[i])
      );

      rgb_pwm_chan #(
         .PWM_BITS       (PWM_BITS),
         .DUTY_RESET     (DUTY_RESET),
         .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
      ) u_g (
         .extra_clk (extra_clk),
         .extra_rst (extra_rst),
         .pwm_cnt   (pwm_cnt),
         .wrap      (wrap),
         .wr_en     (wr_g),
         .wr_duty   (cfg_duty),
         .en        (en_g[i]),
         .pwm_out   (pwm_g[i])
      );

      rgb_pwm_chan #(
         .PWM_BITS       (PWM_BITS),
         .DUTY_RESET     (DUTY_RESET),
         .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
      ) u_b (
         .extra_clk (extra_clk),
         .extra_rst (extra_rst),
         .pwm_cnt   (pwm_cnt),
         .wrap      (wrap),
         .wr_en     (wr_b),
         .wr_duty   (cfg_duty),
         .en        (en_b[i]),
         .pwm_out   (pwm_b[i])
      );
   end

endmodule

// File: doc/rgb_led_pwm.md
Name: rgb_led_pwm

Overview:
Per-LED, per-channel PWM brightness stage that sits directly downstream of the RGB blink generator. It consumes the generator's on/off colour bits (led_r/led_g/led_b) as enables and produces dimmed pad-level drive signals. Duty values are loaded through a valid/ready config port and are double-buffered so that brightness changes only at PWM period boundaries, which keeps the outputs glitch-free.

Parameters:
LED_NUM, 1, number of RGB LEDs (1..16)
PWM_BITS, 8, duty/counter width; PWM period = 2^PWM_BITS ticks
PRESCALE, 256, extra_clk cycles per PWM tick (>=1)
DUTY_RESET, 128, reset duty loaded into every shadow and active register
LED_ACTIVE_LOW, 1, 1 = pad drive inverted (LED lit when pin low)

Ports:
extra_clk  in  1  sole clock
extra_rst  in  1  synchronous, active-high reset
en_r  in  LED_NUM  red enable per LED, from the blink generator
en_g  in  LED_NUM  green enable per LED
en_b  in  LED_NUM  blue enable per LED
cfg_valid  in  1  duty write request
cfg_ready  out  1  duty write accept
cfg_led  in  4  target LED index
cfg_chan  in  2  0=R 1=G 2=B, 3=reserved
cfg_duty  in  PWM_BITS  new duty value
cfg_err  out  1  one-cycle pulse: accepted write was illegal and dropped
pwm_r  out  LED_NUM  red pad drive
pwm_g  out  LED_NUM  green pad drive
pwm_b  out  LED_NUM  blue pad drive
period_start  out  1  one-cycle pulse on the first cycle of each PWM period

Behaviour:
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1). With PRESCALE=1, tick is held high.
- PWM counter: pwm_cnt (PWM_BITS wide) increments on tick and wraps from 2^PWM_BITS-1 to 0. wrap = tick && pwm_cnt == all-ones.
- Duty storage: each of 3*LED_NUM channels has a shadow and an active register.
  - Writes go to shadow only.
  - On wrap, all active <= shadow in the same cycle.
- Lit condition (internal): lit = en && (pwm_cnt < active).
  - duty 0 = always off.
  - duty 2^PWM_BITS-1 = on for (2^PWM_BITS-1)/2^PWM_BITS of the period. Full-on is not supported.
- Output registers: pwm_x <= lit XOR LED_ACTIVE_LOW. Latency is 1 cycle from en_x or from a pwm_cnt/active change to the pad.
- period_start: registered; asserted the cycle after wrap, aligned with pwm_cnt == 0.
- Config handshake:
  - cfg_ready is 1 whenever not in reset; a write is accepted when cfg_valid && cfg_ready.
  - cfg_valid is not required to hold; there is no back-pressure beyond reset.
  - An accepted write with cfg_led >= LED_NUM or cfg_chan == 3 updates nothing and pulses cfg_err the next cycle.
  - A legal write updates the shadow the next cycle.
- Simultaneous write and wrap: the active copy takes the pre-write shadow value; the new value goes live at the following wrap.
- Back-to-back writes to the same channel: last write wins.
- en_x toggling mid-period: takes effect after 1 cycle with no period alignment. The blink enable gates; it does not restart the PWM.
- Reset (extra_rst=1, any cycle, including mid-period or during a write):
  - pre_cnt=0, pwm_cnt=0.
  - All shadow and active registers = DUTY_RESET.
  - pwm_r/g/b = {LED_NUM{LED_ACTIVE_LOW}} (LEDs dark).
  - period_start=0, cfg_err=0, cfg_ready=0.
  - A cfg_valid present in the reset cycle is discarded.
  - First cycle after reset release: cfg_ready=1 and counting resumes from 0.
- Widths: cfg_led is fixed at 4 bits. Indices >= LED_NUM are illegal, per the cfg_err rule.

Decomposition:
- Shared package rgb_led_pkg holds:
  - channel enum CH_R=0, CH_G=1, CH_B=2, CH_RSVD=3
  - CFG_LED_W=4
  - default constants for PWM_BITS, PRESCALE, DUTY_RESET
- One sub-module, rgb_pwm_chan, instanced 3*LED_NUM times. Each instance holds the shadow/active pair, the compare and the output flop, and takes shared pwm_cnt, wrap, its write strobe and en.
- Prescaler, PWM counter and config decode stay in the top.

Test Plan:
- Reset, PRESCALE=1, LED_NUM=1, en_r=1 -> pwm_r low (active-low lit) for 128 of every 256 cycles; period_start every 256 cycles, aligned with pwm_cnt=0.
- Write R duty 64 mid-period -> current period keeps 128 low cycles; next period shows 64 low cycles; cfg_err stays 0.
- Write duty 0 then 255 to G -> pwm_g high the full period, then low 255 of 256 cycles; never low 256.
- Write cfg_chan=3, then cfg_led=5 with LED_NUM=2 -> cfg_err pulses once per write; all pwm outputs unchanged.
- Write issued on the exact wrap cycle -> new duty appears one period later than a write one cycle earlier.
- Assert extra_rst for 1 cycle mid-period with en_b=1 and duty 200 -> next cycle pwm_b=1 (dark), cfg_ready=0; after release the duty is 128 and pwm_cnt restarts at 0.
